// File: rtl/rsa_loader_pkg.sv
// Shared types and sizing for the RSA byte-stream loader.
package rsa_pkg;

  localparam int NBITS_DEF = 256;
  localparam int CNT_W     = $clog2(NBITS_DEF / 8);

  typedef enum logic [2:0] {
    S_LOAD_N = 3'd0,
    S_LOAD_E = 3'd1,
    S_LOAD_C = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_SEND   = 3'd5
  } rsa_state_t;

endpackage

// File: rtl/rsa_loader_if.sv
// Byte-stream and exponentiation-core signals seen by the loader.
interface rsa_loader_if #(
  parameter int NBITS = 256
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_ready;
  logic             pow_start;
  logic [NBITS-1:0] pow_a1;
  logic [NBITS-1:0] pow_a2;
  logic [NBITS-1:0] pow_a3;
  logic             pow_done;
  logic [NBITS-1:0] pow_a0;

  // slave = the loader, master = byte source/sink plus the core
  modport slave (
    input  in_valid, in_data, out_ready, pow_done, pow_a0,
    output in_ready, out_valid, out_data, pow_start, pow_a1, pow_a2, pow_a3
  );

  modport master (
    output in_valid, in_data, out_ready, pow_done, pow_a0,
    input  in_ready, out_valid, out_data, pow_start, pow_a1, pow_a2, pow_a3
  );
endinterface

// File: rtl/rsa_loader_byte_shifter.sv
// NBITS shift register: parallel load, or shift left by one byte with a new low byte.
module rsa_byte_shifter #(
  parameter int NBITS    = 256,
  parameter int BYTE_SEL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [NBITS-1:0] load_data_i,
  input  logic             shift_i,
  input  logic [7:0]       byte_i,
  output logic [NBITS-1:0] q_o,
  output logic [7:0]       byte_o
);

  logic [NBITS-1:0] sr_q;
  logic [NBITS-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[NBITS-9:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q;
  // BYTE_SEL counts bytes down from the MSB end
  assign byte_o = sr_q[NBITS-1-8*BYTE_SEL -: 8];

endmodule

// File: rtl/rsa_loader.sv
// Loads N, E and ciphertext blocks from a byte stream, starts the core, streams results.
//   state    | meaning
//   S_LOAD_N | shifting in modulus bytes
//   S_LOAD_E | shifting in exponent bytes
//   S_LOAD_C | shifting in a ciphertext block
//   S_START  | one-cycle start pulse to the core
//   S_WAIT   | operands frozen, waiting for pow_done
//   S_SEND   | streaming result bytes, top byte dropped
module rsa_loader
  import rsa_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  rsa_loader_if.slave bus
);

  localparam int IN_BYTES  = NBITS / 8;
  localparam int OUT_BYTES = NBITS / 8 - 1;
  localparam int CW        = $clog2(IN_BYTES);
  localparam logic [CW-1:0] CNT_LAST_IN  = CW'(IN_BYTES - 1);
  localparam logic [CW-1:0] CNT_LAST_OUT = CW'(OUT_BYTES - 1);

  rsa_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic in_ready, out_valid, pow_start;
  logic in_acc, out_acc;
  logic last_in, last_out;

  logic [7:0]       n_byte_unused, e_byte_unused, c_byte_unused;
  logic [NBITS-1:0] osr_q_unused;
  logic [7:0]       osr_byte;

  assign in_acc   = bus.in_valid && in_ready;
  assign out_acc  = out_valid && bus.out_ready;
  assign last_in  = (cnt_q == CNT_LAST_IN);
  assign last_out = (cnt_q == CNT_LAST_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD_N;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD_N: if (in_acc && last_in) state_d = S_LOAD_E;
      S_LOAD_E: if (in_acc && last_in) state_d = S_LOAD_C;
      S_LOAD_C: if (in_acc && last_in) state_d = S_START;
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (bus.pow_done) state_d = S_SEND;
      S_SEND:   if (out_acc && last_out) state_d = S_LOAD_C;
      default:  state_d = S_LOAD_N;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (in_acc) begin
      cnt_d = last_in ? '0 : cnt_q + CW'(1);
    end else if (out_acc) begin
      cnt_d = last_out ? '0 : cnt_q + CW'(1);
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    pow_start = 1'b0;
    case (state_q)
      S_LOAD_N, S_LOAD_E, S_LOAD_C: in_ready  = 1'b1;
      S_START:                      pow_start = 1'b1;
      S_SEND:                       out_valid = 1'b1;
      default: ;
    endcase
  end

  rsa_byte_shifter #(.NBITS(NBITS), .BYTE_SEL(0)) u_n (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (in_acc && state_q == S_LOAD_N),
    .byte_i      (bus.in_data),
    .q_o         (bus.pow_a3),
    .byte_o      (n_byte_unused)
  );

  rsa_byte_shifter #(.NBITS(NBITS), .BYTE_SEL(0)) u_e (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (in_acc && state_q == S_LOAD_E),
    .byte_i      (bus.in_data),
    .q_o         (bus.pow_a2),
    .byte_o      (e_byte_unused)
  );

  rsa_byte_shifter #(.NBITS(NBITS), .BYTE_SEL(0)) u_c (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_i     (in_acc && state_q == S_LOAD_C),
    .byte_i      (bus.in_data),
    .q_o         (bus.pow_a1),
    .byte_o      (c_byte_unused)
  );

  // Result register presents its second byte so the top result byte is never sent.
  rsa_byte_shifter #(.NBITS(NBITS), .BYTE_SEL(1)) u_osr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (state_q == S_WAIT && bus.pow_done),
    .load_data_i (bus.pow_a0),
    .shift_i     (out_acc),
    .byte_i      (8'h00),
    .q_o         (osr_q_unused),
    .byte_o      (osr_byte)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.pow_start = pow_start;
  assign bus.out_data  = osr_byte;

endmodule

// File: tb/tb_rsa_loader.sv
// Directed bench for rsa_loader with a mock exponentiation core.
module tb_rsa_loader;

  localparam logic [255:0] KEY_N = 256'hE07122F2A4A9E81141ADE518A2CD7574DCB67060B005E24665EF532E0CCA73E1;
  localparam logic [255:0] KEY_E = 256'h10001;
  localparam logic [255:0] C0    = 256'h00412820616369726641206874756F53202C48544542415A494C452054524F50;
  localparam logic [255:0] RAMP  = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [255:0] A0_2  = 256'hFFEEDDCCBBAA99887766554433221100F0E1D2C3B4A5968778695A4B3C2D1E0F;

  typedef struct {
    logic [255:0] c;
    logic [255:0] a0;
    bit           gaps;
    bit           bp;
    int           spur;
  } blk_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  blk_t tbl[3];

  rsa_loader_if #(.NBITS(256)) bus ();

  rsa_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic load_word(input logic [255:0] w, input bit gaps);
    for (int i = 0; i < 32; i++) send_byte(w[255-8*i -: 8], gaps);
  endtask

  task automatic run_block(input blk_t b);
    int wait_err, got, stab_err, ir_err;
    bit stalled, fin;
    logic [7:0] prev;
    logic [7:0] rx[32];

    for (int i = 0; i < 32; i++) begin
      if (b.spur != 0 && b.spur == i) begin
        bus.pow_done = 1'b1;
        bus.pow_a0   = ~b.a0;
        @(posedge clk); #1;
        bus.pow_done = 1'b0;
        chk("spur_in_ready", bus.in_ready, 1'b1);
        chk("spur_out_valid", bus.out_valid, 1'b0);
      end
      if (i == 31) chk("start_pre", bus.pow_start, 1'b0);
      send_byte(b.c[255-8*i -: 8], b.gaps);
    end

    chk("start_pulse", bus.pow_start, 1'b1);
    chk("pow_a1", bus.pow_a1, b.c);
    chk("pow_a2", bus.pow_a2, KEY_E);
    chk("pow_a3", bus.pow_a3, KEY_N);
    @(posedge clk); #1;
    chk("start_end", bus.pow_start, 1'b0);

    wait_err = 0;
    for (int k = 0; k < 9; k++) begin
      if (bus.in_ready || bus.pow_start || bus.out_valid) wait_err++;
      @(posedge clk); #1;
    end
    chk("wait_quiet", wait_err, 0);
    chk("wait_a1_held", bus.pow_a1, b.c);

    bus.pow_a0   = b.a0;
    bus.pow_done = 1'b1;
    @(posedge clk); #1;
    bus.pow_done = 1'b0;
    bus.pow_a0   = ~b.a0;
    chk("first_valid", bus.out_valid, 1'b1);

    got = 0; stab_err = 0; ir_err = 0; stalled = 1'b0; fin = 1'b0; prev = 8'h00;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (bus.out_valid) begin
        if (bus.in_ready) ir_err++;
        if (stalled && bus.out_data !== prev) stab_err++;
        if (bus.out_ready) begin
          if (got < 32) rx[got] = bus.out_data;
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev    = bus.out_data;
        end
        @(posedge clk); #1;
        if (b.bp) bus.out_ready = ~bus.out_ready;
      end else begin
        fin = 1'b1;
      end
    end
    bus.out_ready = 1'b1;

    chk("rx_finished", fin, 1'b1);
    chk("rx_count", got, 31);
    for (int k = 1; k < 32; k++) chk("rx_byte", rx[k-1], b.a0[255-8*k -: 8]);
    chk("rx_stable", stab_err, 0);
    chk("rx_in_ready_low", ir_err, 0);
    chk("after_in_ready", bus.in_ready, 1'b1);
    chk("after_a3_kept", bus.pow_a3, KEY_N);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    tbl[0] = '{c: C0,                  a0: RAMP, gaps: 1'b0, bp: 1'b0, spur: 0};
    tbl[1] = '{c: {32{8'hA5}},         a0: RAMP, gaps: 1'b1, bp: 1'b1, spur: 0};
    tbl[2] = '{c: {8{32'hDEADBEEF}},   a0: A0_2, gaps: 1'b0, bp: 1'b1, spur: 5};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;
    bus.pow_done  = 1'b0;
    bus.pow_a0    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_pow_start", bus.pow_start, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_a1", bus.pow_a1, '0);
    chk("rst_a2", bus.pow_a2, '0);
    chk("rst_a3", bus.pow_a3, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // pow_done in LOAD_N must not start a send
    bus.pow_done = 1'b1;
    bus.pow_a0   = RAMP;
    @(posedge clk); #1;
    bus.pow_done = 1'b0;
    chk("loadn_done_ignored", bus.out_valid, 1'b0);

    load_word(KEY_N, 1'b0);
    chk("load_n", bus.pow_a3, KEY_N);
    chk("load_n_a2_zero", bus.pow_a2, '0);
    load_word(KEY_E, 1'b0);
    chk("load_e", bus.pow_a2, KEY_E);
    chk("load_e_a3_kept", bus.pow_a3, KEY_N);

    for (int bi = 0; bi < 3; bi++) run_block(tbl[bi]);

    // Reset while the core is busy
    load_word({32{8'h5A}}, 1'b0);
    chk("mid_start", bus.pow_start, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", bus.in_ready, 1'b1);
    chk("async_pow_start", bus.pow_start, 1'b0);
    chk("async_out_valid", bus.out_valid, 1'b0);
    chk("async_out_data", bus.out_data, 8'h00);
    chk("async_a1", bus.pow_a1, '0);
    chk("async_a2", bus.pow_a2, '0);
    chk("async_a3", bus.pow_a3, '0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.pow_done = 1'b1;
    bus.pow_a0   = RAMP;
    @(posedge clk); #1;
    bus.pow_done = 1'b0;
    chk("post_rst_done_ignored", bus.out_valid, 1'b0);
    chk("post_rst_in_ready", bus.in_ready, 1'b1);
    load_word({16{16'h1122}}, 1'b1);
    chk("reload_n", bus.pow_a3, {16{16'h1122}});
    chk("reload_a2_zero", bus.pow_a2, '0);
    chk("reload_a1_zero", bus.pow_a1, '0);
    chk("reload_in_ready", bus.in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsa_loader.md
# rsa_loader

Byte-stream front end for the 256-bit modular exponentiation core (`Power`: a0 = a1^a2 mod a3). It assembles the modulus N, exponent E and successive ciphertext blocks C from an 8-bit valid/ready stream and issues a one-cycle `start` to the core. It then waits for `done`, captures the result and streams the plaintext bytes back out. The block sits directly upstream of the core and also consumes its result, between the serial byte interface and `Power`.

## Interface
- `NBITS`, 256: operand width; must be a multiple of 8.
- `IN_BYTES`, NBITS/8: bytes per loaded operand.
- `OUT_BYTES`, NBITS/8-1: result bytes emitted per block; the top byte is dropped.

- `clk`  in  1  clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  input byte valid.
- `in_data`  in  8  input byte, MSB-first within each operand.
- `in_ready`  out  1  loader accepts a byte.
- `pow_start`  out  1  one-cycle start pulse to the core.
- `pow_a1`  out  NBITS  ciphertext C.
- `pow_a2`  out  NBITS  exponent E.
- `pow_a3`  out  NBITS  modulus N.
- `pow_done`  in  1  core finished.
- `pow_a0`  in  NBITS  core result.
- `out_valid`  out  1  output byte valid.
- `out_data`  out  8  output byte, MSB-first.
- `out_ready`  in  1  sink accepts the byte.

## Operation
- FSM states:
  - LOAD_N: load the modulus N.
  - LOAD_E: load the exponent E.
  - LOAD_C: load a ciphertext block C.
  - START: pulse the core.
  - WAIT: wait for the core to finish.
  - SEND: stream the result out.
- The reset state is LOAD_N.
- Byte handshake: a byte is accepted on a rising edge where `in_valid && in_ready`. `in_ready` = state ∈ {LOAD_N, LOAD_E, LOAD_C}.
- Shift rule for the selected operand register: reg <= {reg[NBITS-9:0], in_data}. The first byte accepted ends up in bits [NBITS-1:NBITS-8].
- Byte counter `cnt` (0..IN_BYTES-1):
  - Increments only on an accepted byte.
  - On the IN_BYTES-th byte it wraps to 0 and the FSM advances: LOAD_N→LOAD_E, LOAD_E→LOAD_C, LOAD_C→START.
- START, lasting one cycle:
  - `pow_start`=1.
  - The next state is WAIT.
- WAIT:
  - `pow_start`=0.
  - `pow_a1/a2/a3` are held constant.
  - On `pow_done`=1: capture `pow_a0` into the output shift register and go to SEND.
- SEND:
  - `out_valid`=1 and `out_data` = osr[NBITS-9:NBITS-16].
  - Each accepted byte (`out_valid && out_ready`) shifts osr left by 8.
  - After OUT_BYTES accepted bytes, `cnt` wraps to 0 and the FSM goes to LOAD_C.
- N and E are retained across blocks. Only `rst_n` reloads the key.
- Operand registers change only on accepted bytes in their own load state. They never change during START, WAIT or SEND.

## Timing
- Reset values:
  - `in_ready`=1 (state LOAD_N).
  - `pow_start`=0.
  - `out_valid`=0.
  - `out_data`=0.
  - `pow_a1`/`pow_a2`/`pow_a3`=0.
  - `cnt`=0.
  - osr=0.
- `pow_start` rises on the clock edge that accepts the last C byte plus one cycle. It is asserted in the cycle after the last C handshake and lasts exactly one cycle.
- `pow_done` is sampled only in WAIT. Any `pow_done` seen in START or in a load state is ignored.
- First output: `out_valid` asserts in the cycle after `pow_done` is sampled high.
- Per-byte throughput: one byte per cycle on both streams when the partner is always ready.
- `in_valid` gaps and `out_ready` stalls:
  - They hold all state.
  - `out_data` must remain stable while `out_valid && !out_ready`.
- Reset mid-operation (any state): asynchronously return to the full reset values. Any later `pow_done` arriving in LOAD_N is ignored.
- Simultaneous `pow_done` and state entry into WAIT cannot occur, because START always intervenes.

## Structure
- Package `rsa_pkg`:
  - `NBITS` default.
  - State enum `rsa_state_t`.
  - Byte-count width localparam `CNT_W` = $clog2(NBITS/8).
- One sub-module, `rsa_byte_shifter`: a parameterised NBITS shift register with load-enable, byte shift-in and top-byte output.
  - Instanced three times for operands N, E and C.
  - Instanced once for osr, using parallel load.

## Test plan
- Load with a mock core:
  - Stimulus: send N = E07122F2A4A9E81141ADE518A2CD7574DCB67060B005E24665EF532E0CCA73E1, then E = 0x10001 (29×0x00, 0x01, 0x00, 0x01), then C = 412820616369726641206874756F53202C48544542415A494C452054524F50 (padded to 32 bytes with a leading 0x00).
  - Required response: `pow_a3`/`pow_a2`/`pow_a1` equal those values, and `pow_start` is high for exactly one cycle, in the cycle after the 96th handshake.
- Result stream:
  - Stimulus: the mock asserts `pow_done` 10 cycles after start, with `pow_a0` = 0x000102…1F.
  - Required response: the output is exactly 31 bytes, 0x01,0x02,…,0x1F, and 0x00 is dropped. Afterwards `in_ready`=1 again.
- Backpressure:
  - Stimulus: toggle `out_ready` every cycle and insert random `in_valid` gaps.
  - Required response: the same 31 bytes, with no duplicate or dropped bytes. `out_data` is stable during stalls. `in_ready`=0 throughout START/WAIT/SEND.
- Second block:
  - Stimulus: after SEND, feed 32 new C bytes 0xA5.
  - Required response: `pow_a3`/`pow_a2` are unchanged, `pow_a1` = all 0xA5, and a new single `pow_start` pulse is issued.
- Spurious done: a `pow_done` pulse during LOAD_C is ignored. The FSM stays in LOAD_C and `cnt` is unchanged.
- Reset mid-WAIT:
  - Stimulus: drop `rst_n` for 2 cycles in WAIT, then release it.
  - Required response: all outputs go to reset values immediately (asynchronously). A later `pow_done` does not cause `out_valid`, and the next 32 bytes load into N.
